// File: rtl/layer_pkg.sv
// Shared definitions for the VGA layer priority arbiter.
// Holds the layer count, index width, named layer indices and the
// configuration FSM state type.
`timescale 1ns/1ps
package layer_pkg;

  localparam int NUM_LAYERS = 6;
  localparam int IDX_W      = 3;

  // Index value meaning "no layer": background winner / disabled slot.
  localparam logic [IDX_W-1:0] NUM_LAYERS_IDX = IDX_W'(NUM_LAYERS);

  localparam int LAYER_COLUMNS = 0;
  localparam int LAYER_BORDERS = 1;
  localparam int LAYER_BLAST   = 2;
  localparam int LAYER_PLAYER  = 3;
  localparam int LAYER_ENEMY   = 4;
  localparam int LAYER_BOMB    = 5;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    APPLY
  } cfg_state_t;

endpackage

// File: rtl/flash_sequencer.sv
// Per-layer hit-flash sequencer.
// Latches the layer to flash, counts frames (startOfFrame pulses) and
// reports whether the current frame is a flash-on frame.
// Ports:
//   clk, resetN     clock, synchronous active-high reset
//   startOfFrame    one-cycle pulse per frame
//   flashReq        start/restart a flash on flashLayer
//   flashLayer      layer to flash (>= NUM_LAYERS ignored)
//   flashBusy       flash in progress
//   flashIdx        latched layer being flashed
//   flashOn         current frame substitutes the flash colour
`timescale 1ns/1ps
module flash_sequencer
  import layer_pkg::*;
#(
  parameter int FLASH_FRAMES = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             flashReq,
  input  logic [IDX_W-1:0] flashLayer,
  output logic             flashBusy,
  output logic [IDX_W-1:0] flashIdx,
  output logic             flashOn
);

  localparam int CNT_W = $clog2(FLASH_FRAMES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [IDX_W-1:0] r_layer;

  always_ff @(posedge clk) begin
    if (resetN) begin
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_layer <= '0;
    end else if (flashReq && (flashLayer < NUM_LAYERS_IDX)) begin
      // A new request always wins, including over a coincident frame pulse.
      r_layer <= flashLayer;
      r_busy  <= 1'b1;
      r_cnt   <= '0;
    end else if (r_busy && startOfFrame) begin
      // Counter never passes FLASH_FRAMES: busy drops on the last step.
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_LAST) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign flashBusy = r_busy;
  assign flashIdx  = r_layer;
  assign flashOn   = r_busy && !r_cnt[0];

endmodule

// File: rtl/layer_priority_arbiter.sv
// Run-time configurable pixel arbiter for the VGA object layers.
// Picks the highest-priority requesting layer from a register table,
// falling back to the background colour. Table updates are written to a
// shadow copy and applied at frame start. A flash sequencer can replace a
// chosen layer's colour with FLASH_RGB on alternate frames.
// Ports:
//   clk, resetN        clock, synchronous active-high reset
//   startOfFrame       one-cycle pulse at first pixel of a frame
//   layerDR/layerRGB   per-layer draw request and colour
//   backgroundRGB      fallback colour
//   cfgValid/cfgReady  shadow-table slot write handshake
//   cfgSlot/cfgLayer   slot (0 = highest) and layer (>= NUM_LAYERS disables)
//   cfgCommit          request shadow -> active at next frame start
//   flashReq/Layer     start a flash; flashBusy while running
//   RGBOut/winnerIdx   arbitrated colour and winner (NUM_LAYERS = background)
//   commitPending      commit accepted, not yet applied
`timescale 1ns/1ps
module layer_priority_arbiter
  import layer_pkg::*;
#(
  parameter int         FLASH_FRAMES = 8,
  parameter logic [7:0] FLASH_RGB    = 8'hFF
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic [NUM_LAYERS-1:0]      layerDR,
  input  logic [NUM_LAYERS-1:0][7:0] layerRGB,
  input  logic [7:0]                 backgroundRGB,
  input  logic                       cfgValid,
  output logic                       cfgReady,
  input  logic [IDX_W-1:0]           cfgSlot,
  input  logic [IDX_W-1:0]           cfgLayer,
  input  logic                       cfgCommit,
  input  logic                       flashReq,
  input  logic [IDX_W-1:0]           flashLayer,
  output logic                       flashBusy,
  output logic [7:0]                 RGBOut,
  output logic [IDX_W-1:0]           winnerIdx,
  output logic                       commitPending
);

  logic [IDX_W-1:0] r_active [NUM_LAYERS];
  logic [IDX_W-1:0] r_shadow [NUM_LAYERS];
  cfg_state_t       r_state;
  logic             r_cfg_ready;
  logic             r_commit_pending;

  logic [IDX_W-1:0] r_s1_idx;
  logic [7:0]       r_s1_rgb;
  logic [7:0]       r_rgb_out;
  logic [IDX_W-1:0] r_winner;

  logic             w_s1_hit;
  logic [IDX_W-1:0] w_s1_idx;
  logic [7:0]       w_s1_rgb;
  logic             w_flash_on;
  logic [IDX_W-1:0] w_flash_idx;

  // Config FSM and both priority tables.
  always_ff @(posedge clk) begin
    if (resetN) begin
      r_state          <= IDLE;
      r_cfg_ready      <= 1'b1;
      r_commit_pending <= 1'b0;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        r_active[i] <= IDX_W'(i);
        r_shadow[i] <= IDX_W'(i);
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (cfgValid && (cfgSlot < NUM_LAYERS_IDX)) begin
            r_shadow[cfgSlot] <= cfgLayer;
          end
          // Frame start in this same cycle is deliberately not honoured.
          if (cfgCommit) begin
            r_state          <= PENDING;
            r_cfg_ready      <= 1'b0;
            r_commit_pending <= 1'b1;
          end
        end
        PENDING: begin
          if (startOfFrame) begin
            r_state <= APPLY;
          end
        end
        APPLY: begin
          for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            r_active[i] <= r_shadow[i];
          end
          r_state          <= IDLE;
          r_cfg_ready      <= 1'b1;
          r_commit_pending <= 1'b0;
        end
        default: begin
          r_state          <= IDLE;
          r_cfg_ready      <= 1'b1;
          r_commit_pending <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1 scan: first enabled slot whose layer requests. Duplicates are
  // naturally served by the lowest slot because the scan stops at the first hit.
  always_comb begin
    w_s1_hit = 1'b0;
    w_s1_idx = NUM_LAYERS_IDX;
    w_s1_rgb = backgroundRGB;
    for (int unsigned s = 0; s < NUM_LAYERS; s++) begin
      if (!w_s1_hit && (r_active[s] < NUM_LAYERS_IDX)) begin
        if (layerDR[r_active[s]]) begin
          w_s1_hit = 1'b1;
          w_s1_idx = r_active[s];
          w_s1_rgb = layerRGB[r_active[s]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      r_s1_idx  <= NUM_LAYERS_IDX;
      r_s1_rgb  <= '0;
      r_rgb_out <= '0;
      r_winner  <= NUM_LAYERS_IDX;
    end else begin
      r_s1_idx <= w_s1_idx;
      r_s1_rgb <= w_s1_rgb;
      r_winner <= r_s1_idx;
      if (w_flash_on && (r_s1_idx == w_flash_idx)) begin
        r_rgb_out <= FLASH_RGB;
      end else begin
        r_rgb_out <= r_s1_rgb;
      end
    end
  end

  flash_sequencer #(
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_flash (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .flashReq    (flashReq),
    .flashLayer  (flashLayer),
    .flashBusy   (flashBusy),
    .flashIdx    (w_flash_idx),
    .flashOn     (w_flash_on)
  );

  assign cfgReady      = r_cfg_ready;
  assign commitPending = r_commit_pending;
  assign RGBOut        = r_rgb_out;
  assign winnerIdx     = r_winner;

endmodule
